logic_fold_unit: RTL



---
 rtl/logic_fold_unit_if.sv | 33 +++
 rtl/logic_fold_unit.sv | 138 +++++++++++++
 2 files changed

// File: rtl/logic_fold_unit_if.sv
// Stream bundle for logic_fold_unit.
// Upstream beat:   i_valid/o_ready handshake, with i_op, i_fold, i_last,
//                  i_a and i_b.
// Downstream:      o_valid/i_ready handshake, with o_c (result),
//                  o_zero (o_c == 0) and o_busy (a fold sequence is open).
// The slave modport is the unit itself. The master modport is the producer
// and consumer side that drives the unit.
interface logic_fold_unit_if #(
  parameter int WIDTH = 8
);
  logic             i_valid;
  logic             o_ready;
  logic [2:0]       i_op;
  logic             i_fold;
  logic             i_last;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
  logic             o_valid;
  logic             i_ready;
  logic [WIDTH-1:0] o_c;
  logic             o_zero;
  logic             o_busy;

  modport slave (
    input  i_valid, i_op, i_fold, i_last, i_a, i_b, i_ready,
    output o_ready, o_valid, o_c, o_zero, o_busy
  );

  modport master (
    output i_valid, i_op, i_fold, i_last, i_a, i_b, i_ready,
    input  o_ready, o_valid, o_c, o_zero, o_busy
  );
endinterface

// File: rtl/logic_fold_unit.sv
// logic_fold_unit: registered bitwise logic engine with optional fold mode.
// Each accepted beat evaluates one of 8 bitwise ops over WIDTH bits.
// A fold sequence chains the op latched on its first beat across the
// following beats. The chained result is emitted on the last beat.
// Ports:
//   i_clk    rising-edge clock
//   i_rst_n  asynchronous active-low reset
//   bus      logic_fold_unit_if.slave, which carries the input and output
//            handshakes, the operands, o_c/o_zero and o_busy
module logic_fold_unit #(
  parameter int WIDTH   = 8,
  parameter bit FOLD_EN = 1'b1
) (
  input logic                i_clk,
  input logic                i_rst_n,
  logic_fold_unit_if.slave   bus
);

  typedef enum logic {S_IDLE, S_FOLD} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_acc;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_c_p1;
  logic             r_zero_p1;
  logic             r_vld_p1;

  logic             w_fold;
  logic             w_ready;
  logic             w_accept;
  logic [2:0]       w_op_sel;
  logic [WIDTH-1:0] w_x;
  logic [WIDTH-1:0] w_res_p0;
  logic             w_load_out;
  logic             w_load_acc;
  logic             w_latch_op;

  // Ops 6 and 7 act on X alone. In fold mode X is the accumulator.
  function automatic logic [WIDTH-1:0] f_logic_op(
    input logic [2:0]       op,
    input logic [WIDTH-1:0] x,
    input logic [WIDTH-1:0] y
  );
    logic [WIDTH-1:0] r;
    case (op)
      3'd0:    r = x & y;
      3'd1:    r = x | y;
      3'd2:    r = ~(x | y);
      3'd3:    r = x ^ y;
      3'd4:    r = ~(x & y);
      3'd5:    r = ~(x ^ y);
      3'd6:    r = ~x;
      default: r = x;
    endcase
    return r;
  endfunction

  assign w_fold   = FOLD_EN ? bus.i_fold : 1'b0;
  assign w_ready  = !r_vld_p1 || bus.i_ready;
  assign w_accept = bus.i_valid && w_ready;

  // Stage p0: select the operands and evaluate the op.
  assign w_op_sel = (r_state == S_FOLD) ? r_op  : bus.i_op;
  assign w_x      = (r_state == S_FOLD) ? r_acc : bus.i_a;
  assign w_res_p0 = f_logic_op(w_op_sel, w_x, bus.i_b);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load_out  = 1'b0;
    w_load_acc  = 1'b0;
    w_latch_op  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_fold && !bus.i_last) begin
            w_state_nxt = S_FOLD;
            w_load_acc  = 1'b1;
            w_latch_op  = 1'b1;
          end else begin
            w_load_out  = 1'b1;
          end
        end
      end
      default: begin
        if (w_accept) begin
          if (bus.i_last) begin
            w_state_nxt = S_IDLE;
            w_load_out  = 1'b1;
          end else begin
            w_load_acc  = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc <= '0;
      r_op  <= 3'd0;
    end else begin
      if (w_load_acc) r_acc <= w_res_p0;
      if (w_latch_op) r_op  <= bus.i_op;
    end
  end

  // Stage p1: output register. A new result loads over a consumed one
  // without a bubble.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_c_p1    <= '0;
      r_zero_p1 <= 1'b0;
      r_vld_p1  <= 1'b0;
    end else if (w_load_out) begin
      r_c_p1    <= w_res_p0;
      r_zero_p1 <= (w_res_p0 == '0);
      r_vld_p1  <= 1'b1;
    end else if (bus.i_ready) begin
      r_vld_p1  <= 1'b0;
    end
  end

  assign bus.o_ready = w_ready;
  assign bus.o_valid = r_vld_p1;
  assign bus.o_c     = r_c_p1;
  assign bus.o_zero  = r_zero_p1;
  assign bus.o_busy  = (r_state == S_FOLD);

endmodule
